// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, address geometry and sequencer state
// shared by the SDRAM log sequencer and its sample FIFO.
package sdram_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ERROR
    } seq_state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sdram_req_t;

endpackage

// File: rtl/sdram_log_sequencer_if.sv
// sdram_log_sequencer_if: command/address/data bus between the log
// sequencer (master) and sdram_interface (slave).
interface sdram_log_sequencer_if;
    import sdram_pkg::*;

    logic [1:0]        CMD_OUT;
    logic [BANK_W-1:0] A_OUT_BANK;
    logic [ROW_W-1:0]  A_OUT_ROW;
    logic [COL_W-1:0]  A_OUT_COL;
    logic [DATA_W-1:0] D_OUT;
    logic              SDRAM_STATUS;
    logic [DATA_W-1:0] SDRAM_DATA_READ;

    modport master (
        output CMD_OUT,
        output A_OUT_BANK,
        output A_OUT_ROW,
        output A_OUT_COL,
        output D_OUT,
        input  SDRAM_STATUS,
        input  SDRAM_DATA_READ
    );

    modport slave (
        input  CMD_OUT,
        input  A_OUT_BANK,
        input  A_OUT_ROW,
        input  A_OUT_COL,
        input  D_OUT,
        output SDRAM_STATUS,
        output SDRAM_DATA_READ
    );

endinterface

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: show-ahead synchronous FIFO for logged samples;
// a push while full is accepted only when a pop happens in the same cycle.
module sdram_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (do_pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            unique case (1'b1)
                do_push && !do_pop: count <= count + 1'b1;
                do_pop && !do_push: count <= count - 1'b1;
                default:            count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_log_sequencer.sv
// sdram_log_sequencer: logs 16-bit samples to a linear 24-bit SDRAM
// address space through sdram_interface and streams the log back on demand.
module sdram_log_sequencer
    import sdram_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  CLK_48MHZ,
    input  logic                  RESET,
    input  logic                  SAMPLE_VALID,
    input  logic [DATA_W-1:0]     SAMPLE_DATA,
    input  logic                  DUMP_REQ,
    sdram_log_sequencer_if.master bus,
    output logic [DATA_W-1:0]     RD_DATA,
    output logic                  RD_VALID,
    output logic                  DUMP_BUSY,
    output logic [ADDR_W-1:0]     WORDS_STORED,
    output logic                  WRAPPED,
    output logic                  OVERFLOW,
    output logic                  TIMEOUT_ERR
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W:0] DUMP_ALL = {1'b1, {ADDR_W{1'b0}}};

    seq_state_t        state_q, state_d;
    sdram_req_t        req_q, req_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wrapped_q, wrapped_d;
    logic              tmo_err_q, tmo_err_d;
    logic              ovf_q;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              drop;

    assign drop = SAMPLE_VALID && fifo_full && !fifo_pop;

    sdram_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (CLK_48MHZ),
        .rst   (RESET),
        .push  (SAMPLE_VALID),
        .pop   (fifo_pop),
        .wdata (SAMPLE_DATA),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            cmd_q      <= CMD_NOP;
            tmo_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wrapped_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            tmo_q      <= tmo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wrapped_q  <= wrapped_d;
            tmo_err_q  <= tmo_err_d;
            ovf_q      <= ovf_q | drop;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        tmo_d      = tmo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wrapped_d  = wrapped_q;
        tmo_err_d  = tmo_err_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Once wrapped, the oldest word sits at the write pointer.
                if (DUMP_REQ && !busy_q) begin
                    if (wrapped_q) begin
                        rd_ptr_d = wr_ptr_q;
                        rem_d    = DUMP_ALL;
                        busy_d   = 1'b1;
                    end else begin
                        rd_ptr_d = '0;
                        rem_d    = {1'b0, wr_ptr_q};
                        busy_d   = |wr_ptr_q;
                    end
                end
                if (!bus.SDRAM_STATUS) begin
                    unique case (1'b1)
                        !fifo_empty: begin
                            fifo_pop   = 1'b1;
                            req_d.op   = CMD_WRITE;
                            req_d.addr = wr_ptr_q;
                            req_d.data = fifo_rdata;
                            state_d    = S_ISSUE;
                        end
                        fifo_empty && busy_q: begin
                            req_d.op   = CMD_READ;
                            req_d.addr = rd_ptr_q;
                            state_d    = S_ISSUE;
                        end
                        default: ;
                    endcase
                end
            end
            S_ISSUE: begin
                cmd_d   = req_q.op;
                tmo_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.SDRAM_STATUS) begin
                    cmd_d   = CMD_NOP;
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    cmd_d     = CMD_NOP;
                    tmo_err_d = 1'b1;
                    state_d   = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.SDRAM_STATUS) begin
                    state_d = S_IDLE;
                    if (req_q.op == CMD_WRITE) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (&wr_ptr_q) begin
                            wrapped_d = 1'b1;
                        end
                    end else begin
                        rd_data_d  = bus.SDRAM_DATA_READ;
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        rem_d      = rem_q - 1'b1;
                        if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                            busy_d = 1'b0;
                        end
                    end
                end
            end
            S_ERROR: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.CMD_OUT    = cmd_q;
    assign bus.A_OUT_BANK = req_q.addr[ADDR_W-1 -: BANK_W];
    assign bus.A_OUT_ROW  = req_q.addr[COL_W +: ROW_W];
    assign bus.A_OUT_COL  = req_q.addr[COL_W-1:0];
    assign bus.D_OUT      = req_q.data;

    assign RD_DATA      = rd_data_q;
    assign RD_VALID     = rd_valid_q;
    assign DUMP_BUSY    = busy_q;
    assign WORDS_STORED = wr_ptr_q;
    assign WRAPPED      = wrapped_q;
    assign OVERFLOW     = ovf_q;
    assign TIMEOUT_ERR  = tmo_err_q;

endmodule
